// File: rtl/ram_pkg.sv
// Shared access-type encodings, FSM state type and access-size helper for the
// sized synchronous RAM.
package ram_pkg;

    localparam logic [1:0] TYPE_BYTE  = 2'b00;
    localparam logic [1:0] TYPE_HALF  = 2'b01;
    localparam logic [1:0] TYPE_WORD  = 2'b10;
    localparam logic [1:0] TYPE_DWORD = 2'b11;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam int MAX_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] type_data);
        case (type_data)
            TYPE_BYTE: size_bytes = 4'd1;
            TYPE_HALF: size_bytes = 4'd2;
            TYPE_WORD: size_bytes = 4'd4;
            default:   size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/ram_byte_lane_ctrl.sv
// Per-byte address generation for a sized access: lane k carries the byte at
// (address + k) mod DEPTH, most-significant byte in lane 0.
module ram_byte_lane_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter bit ALIGN_CHECK = 1'b0
) (
    input  logic [ADDR_W-1:0]                  address_i,
    input  logic [1:0]                         type_data_i,
    output logic [MAX_BYTES-1:0][ADDR_W-1:0]   lane_addr_o,
    output logic [MAX_BYTES-1:0]               lane_en_o,
    output logic                               misaligned_o
);

    logic [3:0] n_bytes;

    always_comb begin
        n_bytes = size_bytes(type_data_i);
        // N is a power of two, so address mod N is just the low address bits.
        misaligned_o = ALIGN_CHECK && ((address_i & ADDR_W'(n_bytes - 4'd1)) != '0);
        for (int k = 0; k < MAX_BYTES; k++) begin
            lane_en_o[k]   = (k < int'(n_bytes));
            lane_addr_o[k] = ADDR_W'((int'(address_i) + k) % DEPTH);
        end
    end

endmodule

// File: rtl/ram_sized_sync.sv
// Byte-addressable big-endian RAM with sized accesses and a four-phase mv/moc
// handshake. Define RAM_SIZED_SYNC_ALIGN_CHECK_EN to suppress misaligned accesses and flag err.
module ram_sized_sync
    import ram_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mv,
    input  logic              rw,
    input  logic [1:0]        type_data,
    input  logic [ADDR_W-1:0] address,
    input  logic [63:0]       data_in,
    output logic [63:0]       data_out,
    output logic              moc,
    output logic              err
);

`ifdef RAM_SIZED_SYNC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic [7:0] mem [DEPTH];

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rw_q;
    logic [1:0]         type_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [63:0]        wdata_q;
    logic [63:0]        dout_q, dout_d;
    logic               err_q, err_d;
    logic               latch_req;
    logic               commit;

    logic [MAX_BYTES-1:0][ADDR_W-1:0] lane_addr;
    logic [MAX_BYTES-1:0]             lane_en;
    logic                             misaligned;
    logic [6:0]                       shamt;
    logic [63:0]                      rd_left, wr_left;

    ram_byte_lane_ctrl #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_lane_ctrl (
        .address_i    (addr_q),
        .type_data_i  (type_q),
        .lane_addr_o  (lane_addr),
        .lane_en_o    (lane_en),
        .misaligned_o (misaligned)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= OP_READ;
            type_q  <= TYPE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            if (latch_req) begin
                rw_q    <= rw;
                type_q  <= type_data;
                addr_q  <= address;
                wdata_q <= data_in;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_req = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mv) begin
                    latch_req = 1'b1;
                    cnt_d     = 4'(WAIT_CYCLES);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!mv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lanes are assembled left-justified, then shifted into the right-justified bus.
    always_comb begin
        shamt = 7'd64 - {size_bytes(type_q), 3'b000};
        wr_left = wdata_q << shamt;
        for (int k = 0; k < MAX_BYTES; k++) begin
            rd_left[63-8*k -: 8] = mem[lane_addr[k]];
        end
        dout_d = dout_q;
        err_d  = err_q;
        if (commit) begin
            err_d = misaligned;
            if (rw_q == OP_READ && !misaligned) dout_d = rd_left >> shamt;
        end
        if (state_q == DONE && !mv) err_d = 1'b0;
    end

    // NOTE: the storage array has no reset; its contents survive reset by design.
    always_ff @(posedge clk) begin
        if (commit && rw_q == OP_WRITE && !misaligned) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
                if (lane_en[k]) mem[lane_addr[k]] <= wr_left[63-8*k -: 8];
            end
        end
    end

    always_comb begin
        moc      = (state_q == DONE);
        err      = err_q;
        data_out = dout_q;
    end

endmodule

// File: tb/tb_ram_sized_sync.sv
// Self-checking bench for ram_sized_sync: directed scenarios plus randomized
// accesses compared against a byte-array reference model.
module tb_ram_sized_sync;
    import ram_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int WAIT1  = 1;
    localparam int WAIT4  = 4;

`ifdef RAM_SIZED_SYNC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, mv, rw;
    logic [1:0]        type_data;
    logic [ADDR_W-1:0] address;
    logic [63:0]       data_in;
    logic [63:0]       data_out;
    logic              moc, err;

    logic              reset4, mv4;
    logic [63:0]       data_out4;
    logic              moc4, err4;

    ram_sized_sync #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT1)) dut (
        .clk(clk), .reset(reset), .mv(mv), .rw(rw), .type_data(type_data),
        .address(address), .data_in(data_in), .data_out(data_out), .moc(moc), .err(err)
    );

    ram_sized_sync #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT4)) dut4 (
        .clk(clk), .reset(reset4), .mv(mv4), .rw(rw), .type_data(type_data),
        .address(address), .data_in(data_in), .data_out(data_out4), .moc(moc4), .err(err4)
    );

    logic [7:0]  model_mem [DEPTH];
    logic [63:0] model_dout;
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: N bytes starting at a, wrapping modulo DEPTH, MSB first.
    task automatic ref_access(input logic r, input logic [1:0] t, input logic [7:0] a,
                              input logic [63:0] d, output logic exp_err);
        int n = 1 << t;
        int idx;
        logic [63:0] v = '0;
        exp_err = ALIGN && ((int'(a) % n) != 0);
        if (exp_err) return;
        for (int k = 0; k < n; k++) begin
            idx = (int'(a) + k) % DEPTH;
            if (r) v = {v[55:0], model_mem[idx]};
            else   model_mem[idx] = d[8*(n-1-k) +: 8];
        end
        if (r) model_dout = v;
    endtask

    // Latency counts edges after the mv-sampling edge; moc must appear on
    // edge WAIT+1 after it (WAIT+2 edges including the sampling edge).
    task automatic access(input logic r, input logic [1:0] t, input logic [7:0] a,
                          input logic [63:0] d, input int hold, input bit early_drop);
        int edges;
        logic exp_err;
        @(negedge clk);
        mv = 1'b1; rw = r; type_data = t; address = a; data_in = d;
        @(posedge clk); #1;
        ref_access(r, t, a, d, exp_err);
        rw = 1'($urandom); type_data = 2'($urandom); address = 8'($urandom);
        data_in = {$urandom, $urandom};
        if (early_drop) mv = 1'b0;
        check("moc_low_after_sample", 64'(moc), 64'd0);
        edges = 0;
        while (moc !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency", 64'(edges), 64'(WAIT1 + 1));
        check("data_out", data_out, model_dout);
        check("err", 64'(err), 64'(exp_err));
        repeat (hold) begin
            @(posedge clk); #1;
            check("moc_hold", 64'(moc), 64'd1);
            check("data_out_hold", data_out, model_dout);
        end
        mv = 1'b0;
        @(posedge clk); #1;
        check("moc_clear", 64'(moc), 64'd0);
        check("err_clear", 64'(err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        int seen;
        logic dummy_err;
        logic [7:0] exp_wrap [8];

        reset = 1'b1; reset4 = 1'b1; mv = 1'b0; mv4 = 1'b0;
        rw = OP_READ; type_data = TYPE_BYTE; address = '0; data_in = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dut.mem[8'(i)]  = 8'(i);
            dut4.mem[8'(i)] = 8'(i);
            model_mem[i]    = 8'(i);
        end
        model_dout = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 64'd0);
        check("reset_moc", 64'(moc), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_moc4", 64'(moc4), 64'd0);
        @(negedge clk);
        reset = 1'b0; reset4 = 1'b0;

        access(OP_READ, TYPE_WORD, 8'd4, 64'd0, 0, 1'b0);
        check("tp_word_read", data_out, 64'h0000_0000_0405_0607);

        access(OP_WRITE, TYPE_BYTE, 8'd2, 64'h9B, 0, 1'b0);
        access(OP_READ, TYPE_BYTE, 8'd2, 64'd0, 0, 1'b0);
        check("tp_byte_read", data_out, 64'h9B);

        access(OP_WRITE, TYPE_HALF, 8'd2, 64'hBEBF, 0, 1'b0);
        access(OP_READ, TYPE_HALF, 8'd2, 64'd0, 0, 1'b0);
        check("tp_half_read", data_out, 64'hBEBF);
        check("tp_mem2", 64'(dut.mem[2]), 64'hBE);
        check("tp_mem3", 64'(dut.mem[3]), 64'hBF);

        access(OP_WRITE, TYPE_DWORD, 8'd248, 64'hCAFE_FEAF_BEBE_ABEF, 0, 1'b0);
        access(OP_READ, TYPE_DWORD, 8'd248, 64'd0, 0, 1'b0);
        check("tp_dword_read", data_out, 64'hCAFE_FEAF_BEBE_ABEF);
        check("tp_mem255", 64'(dut.mem[255]), 64'hEF);

        access(OP_WRITE, TYPE_DWORD, 8'd252, 64'hCAFE_FEAF_BEBE_ABEF, 0, 1'b0);
`ifdef RAM_SIZED_SYNC_ALIGN_CHECK_EN
        exp_wrap = '{8'hBE, 8'hBE, 8'hAB, 8'hEF, 8'hBE, 8'hBF, 8'h02, 8'h03};
        exp_wrap[4] = model_mem[0]; exp_wrap[5] = model_mem[1];
        exp_wrap[6] = model_mem[2]; exp_wrap[7] = model_mem[3];
`else
        exp_wrap = '{8'hCA, 8'hFE, 8'hFE, 8'hAF, 8'hBE, 8'hBE, 8'hAB, 8'hEF};
`endif
        for (int k = 0; k < 8; k++) begin
            check("tp_wrap_mem", 64'(dut.mem[8'(252 + k)]), 64'(exp_wrap[k]));
        end

        // moc held while mv stays high; no second access despite scrambled inputs.
        access(OP_READ, TYPE_WORD, 8'd8, 64'd0, 3, 1'b0);
        // mv dropped before moc: access still completes.
        access(OP_READ, TYPE_HALF, 8'd5, 64'd0, 0, 1'b1);

        access(OP_WRITE, TYPE_WORD, 8'd6, 64'h5566_7788, 0, 1'b0);
        for (int k = 6; k < 10; k++) begin
            check("align_mem", 64'(dut.mem[8'(k)]), 64'(model_mem[k]));
        end
        access(OP_READ, TYPE_WORD, 8'd8, 64'd0, 0, 1'b0);

        // Reset while in DONE drops moc without waiting for a clock edge.
        @(negedge clk);
        mv = 1'b1; rw = OP_READ; type_data = TYPE_BYTE; address = 8'h10;
        @(posedge clk); #1;
        ref_access(OP_READ, TYPE_BYTE, 8'h10, 64'd0, dummy_err);
        edges = 0;
        while (moc !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("done_reached", 64'(moc), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_moc_drop", 64'(moc), 64'd0);
        check("async_data_out", data_out, 64'd0);
        model_dout = '0;
        @(negedge clk);
        reset = 1'b0; mv = 1'b0;

        // Abort two cycles into BUSY on the 4-wait-state instance.
        @(negedge clk);
        mv4 = 1'b1; rw = OP_WRITE; type_data = TYPE_WORD; address = 8'd8;
        data_in = 64'h1122_3344;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 reset4 = 1'b1; mv4 = 1'b0;
        #1;
        check("abort_moc", 64'(moc4), 64'd0);
        check("abort_data_out", data_out4, 64'd0);
        @(negedge clk);
        reset4 = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (moc4) seen++;
        end
        check("abort_no_moc", 64'(seen), 64'd0);
        for (int k = 8; k < 12; k++) begin
            check("abort_mem", 64'(dut4.mem[8'(k)]), 64'(k));
        end

        @(negedge clk);
        mv4 = 1'b1; rw = OP_READ; type_data = TYPE_WORD; address = 8'd8;
        @(posedge clk); #1;
        edges = 0;
        while (moc4 !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency_w4", 64'(edges), 64'(WAIT4 + 1));
        check("read_w4", data_out4, 64'h0000_0000_0809_0A0B);
        mv4 = 1'b0;
        @(posedge clk); #1;
        check("moc4_clear", 64'(moc4), 64'd0);

        repeat (60) begin
            logic       r;
            logic [1:0] t;
            logic [7:0] a;
            logic [63:0] d;
            bit         early;
            r = 1'($urandom); t = 2'($urandom); a = 8'($urandom);
            d = {$urandom, $urandom};
            early = ($urandom_range(0, 3) == 0);
            access(r, t, a, d, early ? 0 : $urandom_range(0, 2), early);
        end

        for (int i = 0; i < DEPTH; i++) begin
            check("final_mem", 64'(dut.mem[8'(i)]), 64'(model_mem[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
